// File: rtl/exec_pkg.sv
// exec_pkg: shared constants and types for the execute stage.
//   - RV32 base opcodes, ALU operation codes, operand bypass selects,
//     the canonical NOP (addi x0,x0,0) and the M-extension funct7.
//   - State enum for the iterative multiply/divide unit.
package exec_pkg;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BCC   = 7'b1100011;
    localparam logic [6:0] OP_LCC   = 7'b0000011;
    localparam logic [6:0] OP_SCC   = 7'b0100011;
    localparam logic [6:0] OP_MCC   = 7'b0010011;
    localparam logic [6:0] OP_RCC   = 7'b0110011;

    localparam logic [1:0]  BYP_MX   = 2'b01;
    localparam logic [1:0]  BYP_WX   = 2'b10;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [6:0]  F7_MDU   = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_sel_e;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mdu_state_e;

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide, one bit per cycle.
//   clk, rst      : clock, synchronous active-high reset
//   start         : an M-extension op is present in X
//   op[2:0]       : funct3 (MUL..REMU)
//   a, b          : rs1 / rs2 operands (held stable by the caller while busy)
//   busy          : stall request (IDLE with start, or RUN)
//   done          : result valid (DONE state)
//   result        : sign-corrected result, registered
// Operands are reduced to magnitudes on entry; the sign is re-applied on
// the final step. Divide-by-zero and signed overflow skip the iteration.
module mdu_iter
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    mdu_state_e        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2*XLEN-1:0] acc_q, acc_d, step_acc, prod_fix;
    logic [XLEN-1:0]   opb_q, opb_d, res_q, res_d, quot_fix, rem_fix, fin_res;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2:0]        op_q, op_d;
    logic              sa_q, sa_d, sb_q, sb_d;
    logic              sign_a, sign_b, div_zero, div_ovf;
    logic [XLEN:0]     mul_sum, div_diff;

    // MULHU, DIVU, REMU treat rs1 as unsigned; MULHSU/MULHU/DIVU/REMU treat rs2 as unsigned.
    assign sign_a   = a[XLEN-1] & ~(op[0] & (op[1] | op[2]));
    assign sign_b   = b[XLEN-1] & ~((~op[2] & op[1]) | (op[2] & op[0]));
    assign mag_a    = sign_a ? -a : a;
    assign mag_b    = sign_b ? -b : b;
    assign div_zero = op[2] & (b == '0);
    assign div_ovf  = op[2] & ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b);

    // Multiply: low half holds the multiplier, shifted out as the product grows in.
    // Divide: {remainder, dividend/quotient} shifted left, restoring subtract on top.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};

    always_comb begin
        step_acc = {mul_sum, acc_q[XLEN-1:1]};
        if (op_q[2]) begin
            if (div_diff[XLEN]) step_acc = {acc_q[2*XLEN-2:0], 1'b0};
            else                step_acc = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
        prod_fix = (sa_q ^ sb_q) ? -step_acc : step_acc;
        quot_fix = (sa_q ^ sb_q) ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
        rem_fix  = sa_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:         fin_res = prod_fix[XLEN-1:0];
            3'b100, 3'b101: fin_res = quot_fix;
            3'b110, 3'b111: fin_res = rem_fix;
            default:        fin_res = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        case (state_q)
            IDLE: if (start) begin
                op_d    = op;
                sa_d    = sign_a;
                sb_d    = sign_b;
                acc_d   = {{XLEN{1'b0}}, mag_a};
                opb_d   = mag_b;
                count_d = '0;
                if (div_zero) begin
                    res_d   = op[1] ? a : '1;
                    state_d = DONE;
                end else if (div_ovf) begin
                    res_d   = op[1] ? '0 : a;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = step_acc;
                count_d = count_q + 1'b1;
                if (count_q == CW'(XLEN-1)) begin
                    res_d   = fin_res;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
        end
    end

    assign busy   = ((state_q == IDLE) & start) | (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = res_q;

endmodule

// File: rtl/execute_mdu.sv
// execute_mdu: X stage of the five-stage RISC-V pipeline.
//   Inputs : clk, rst (sync, active-high), PC_d/inst_d/rs1_d/rs2_d from decode,
//            alu_m_bypass/wb_w_bypass with rs1_bypass/rs2_bypass selects.
//   Outputs: PC_x, inst_x, alu_x, rs2_x (store data), valid_x, busy_x (stall),
//            PCSel (redirect), kill_dx (squash D and X), illegal_x.
// Build option EXEC_MDU_EN: when defined the iterative multiply/divide unit is
// present and stalls the front end; otherwise M-extension ops flag illegal_x.
module execute_mdu
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] PC_d,
    input  logic [XLEN-1:0] rs1_d,
    input  logic [XLEN-1:0] rs2_d,
    input  logic [31:0]     inst_d,
    input  logic [XLEN-1:0] alu_m_bypass,
    input  logic [XLEN-1:0] wb_w_bypass,
    input  logic [1:0]      rs1_bypass,
    input  logic [1:0]      rs2_bypass,
    output logic [XLEN-1:0] PC_x,
    output logic [31:0]     inst_x,
    output logic [XLEN-1:0] alu_x,
    output logic [XLEN-1:0] rs2_x,
    output logic            valid_x,
    output logic            busy_x,
    output logic            PCSel,
    output logic            kill_dx,
    output logic            illegal_x
);
    localparam int SW = $clog2(XLEN);

    logic [XLEN-1:0] pc_q, rs_q [2], rs_src [2];
    logic [31:0]     inst_q;
    logic [1:0]      byp_sel [2];
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm, op_a, op_b, alu_out;
    alu_sel_e        alu_sel;
    logic            is_mdu, br_taken, pcsel_raw, kill_raw;

    assign byp_sel[0] = rs1_bypass;
    assign byp_sel[1] = rs2_bypass;

    for (genvar gi = 0; gi < 2; gi++) begin : g_byp
        assign rs_src[gi] = (byp_sel[gi] == BYP_MX) ? alu_m_bypass :
                            (byp_sel[gi] == BYP_WX) ? wb_w_bypass  :
                            (gi == 0) ? rs1_d : rs2_d;
    end

    // Reset wins over the stall so a mid-operation reset flushes X immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            inst_q  <= NOP_INST;
            rs_q[0] <= '0;
            rs_q[1] <= '0;
        end else if (!busy_x) begin
            if (kill_dx) begin
                pc_q    <= '0;
                inst_q  <= NOP_INST;
                rs_q[0] <= '0;
                rs_q[1] <= '0;
            end else begin
                pc_q    <= PC_d;
                inst_q  <= inst_d;
                rs_q[0] <= rs_src[0];
                rs_q[1] <= rs_src[1];
            end
        end
    end

    assign opcode = inst_q[6:0];
    assign funct3 = inst_q[14:12];
    assign funct7 = inst_q[31:25];
    assign is_mdu = (opcode == OP_RCC) && (funct7 == F7_MDU);

    always_comb begin
        case (opcode)
            OP_LUI, OP_AUIPC: imm = XLEN'($signed({inst_q[31:12], 12'b0}));
            OP_JAL:  imm = XLEN'($signed({inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0}));
            OP_BCC:  imm = XLEN'($signed({inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0}));
            OP_SCC:  imm = XLEN'($signed({inst_q[31:25], inst_q[11:7]}));
            default: imm = XLEN'($signed(inst_q[31:20]));
        endcase
    end

    always_comb begin
        alu_sel = ALU_ADD;
        case (opcode)
            OP_LUI: alu_sel = ALU_PASSB;
            OP_MCC, OP_RCC: begin
                case (funct3)
                    3'b000:  alu_sel = (opcode == OP_RCC && funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_sel = ALU_SLL;
                    3'b010:  alu_sel = ALU_SLT;
                    3'b011:  alu_sel = ALU_SLTU;
                    3'b100:  alu_sel = ALU_XOR;
                    3'b101:  alu_sel = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_sel = ALU_OR;
                    default: alu_sel = ALU_AND;
                endcase
            end
            default: alu_sel = ALU_ADD;
        endcase
    end

    assign op_a = (opcode == OP_JAL || opcode == OP_AUIPC || opcode == OP_BCC) ? pc_q : rs_q[0];
    assign op_b = (opcode == OP_RCC) ? rs_q[1] : imm;

    always_comb begin
        case (alu_sel)
            ALU_SUB:   alu_out = op_a - op_b;
            ALU_SLL:   alu_out = op_a << op_b[SW-1:0];
            ALU_SLT:   alu_out = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:  alu_out = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_XOR:   alu_out = op_a ^ op_b;
            ALU_SRL:   alu_out = op_a >> op_b[SW-1:0];
            ALU_SRA:   alu_out = $unsigned($signed(op_a) >>> op_b[SW-1:0]);
            ALU_OR:    alu_out = op_a | op_b;
            ALU_AND:   alu_out = op_a & op_b;
            ALU_PASSB: alu_out = op_b;
            default:   alu_out = op_a + op_b;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  br_taken = (rs_q[0] == rs_q[1]);
            3'b001:  br_taken = (rs_q[0] != rs_q[1]);
            3'b100:  br_taken = ($signed(rs_q[0]) <  $signed(rs_q[1]));
            3'b101:  br_taken = ($signed(rs_q[0]) >= $signed(rs_q[1]));
            3'b110:  br_taken = (rs_q[0] <  rs_q[1]);
            3'b111:  br_taken = (rs_q[0] >= rs_q[1]);
            default: br_taken = 1'b0;
        endcase
    end

    assign kill_raw  = (opcode == OP_JALR) || (opcode == OP_BCC && br_taken);
    assign pcsel_raw = kill_raw || (opcode == OP_JAL);
    assign PCSel     = pcsel_raw & ~busy_x;
    assign kill_dx   = kill_raw & ~busy_x;

`ifdef EXEC_MDU_EN
    logic            mdu_busy, mdu_done;
    logic [XLEN-1:0] mdu_result;

    mdu_iter #(.XLEN(XLEN)) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (is_mdu),
        .op     (funct3),
        .a      (rs_q[0]),
        .b      (rs_q[1]),
        .busy   (mdu_busy),
        .done   (mdu_done),
        .result (mdu_result)
    );

    assign busy_x    = mdu_busy;
    assign valid_x   = ~is_mdu | mdu_done;
    assign illegal_x = 1'b0;
    assign alu_x     = is_mdu ? mdu_result : alu_out;
`else
    assign busy_x    = 1'b0;
    assign valid_x   = 1'b1;
    assign illegal_x = is_mdu;
    assign alu_x     = is_mdu ? '0 : alu_out;
`endif

    assign PC_x   = pc_q;
    assign inst_x = inst_q;
    assign rs2_x  = rs_q[1];

endmodule

// File: tb/tb_execute_mdu.sv
// tb_execute_mdu: randomized self-checking bench for execute_mdu (XLEN=32).
// Expected values come from ISA-level arithmetic on the chosen operation and
// operands. MDU scenarios are exercised when EXEC_MDU_EN is defined; otherwise
// the illegal-opcode path is exercised.
module tb_execute_mdu;
    localparam int XLEN = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC_d, rs1_d, rs2_d, inst_d, alu_m_bypass, wb_w_bypass;
    logic [1:0]  rs1_bypass, rs2_bypass;
    logic [31:0] PC_x, inst_x, alu_x, rs2_x;
    logic        valid_x, busy_x, PCSel, kill_dx, illegal_x;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    execute_mdu #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .PC_d(PC_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .inst_d(inst_d),
        .alu_m_bypass(alu_m_bypass), .wb_w_bypass(wb_w_bypass),
        .rs1_bypass(rs1_bypass), .rs2_bypass(rs2_bypass),
        .PC_x(PC_x), .inst_x(inst_x), .alu_x(alu_x), .rs2_x(rs2_x), .valid_x(valid_x),
        .busy_x(busy_x), .PCSel(PCSel), .kill_dx(kill_dx), .illegal_x(illegal_x)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3, input logic [6:0] op);
        return {imm, 5'd1, f3, 5'd3, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm);
        return {imm[11:5], 5'd2, 5'd1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] d, input logic [31:0] mx, input logic [31:0] wx);
        return (s == 2'b01) ? mx : (s == 2'b10) ? wx : d;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input bit alt, input logic [31:0] x, input logic [31:0] y);
        logic [4:0] sh;
        sh = y[4:0];
        case (f3)
            3'd0: return alt ? x - y : x + y;
            3'd1: return x << sh;
            3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: return (x < y) ? 32'd1 : 32'd0;
            3'd4: return x ^ y;
            3'd5: return alt ? $unsigned($signed(x) >>> sh) : x >> sh;
            3'd6: return x | y;
            default: return x & y;
        endcase
    endfunction

    function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
        case (f3)
            3'd0: return x == y;
            3'd1: return x != y;
            3'd4: return $signed(x) < $signed(y);
            3'd5: return $signed(x) >= $signed(y);
            3'd6: return x < y;
            default: return x >= y;
        endcase
    endfunction

    function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub_s;
        logic [63:0] p, ua, ub;
        sa = $signed(a); sb = $signed(b);
        ua = {32'd0, a}; ub = {32'd0, b}; ub_s = $signed(ub);
        case (f3)
            3'd0: begin p = sa * sb;   return p[31:0];  end
            3'd1: begin p = sa * sb;   return p[63:32]; end
            3'd2: begin p = sa * ub_s; return p[63:32]; end
            3'd3: begin p = ua * ub;   return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2);
        PC_d = pc; inst_d = inst; rs1_d = r1; rs2_d = r2;
        rs1_bypass = 2'b00; rs2_bypass = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(32'h1234, enc_b(13'd64, 3'd0), 32'd9, 32'd9);
        step(); step();
        checks++; if (PC_x !== 32'd0) begin errors++; $display("FAIL reset_pc got %h want 0", PC_x); end
        checks++; if (inst_x !== NOP) begin errors++; $display("FAIL reset_inst got %h want 13", inst_x); end
        checks++; if (alu_x !== 32'd0) begin errors++; $display("FAIL reset_alu got %h want 0", alu_x); end
        checks++; if ({valid_x, busy_x, PCSel, kill_dx, illegal_x} !== 5'b10000)
            begin errors++; $display("FAIL reset_flags got %b want 10000", {valid_x, busy_x, PCSel, kill_dx, illegal_x}); end
        $display("txn reset pc=%h inst=%h", PC_x, inst_x);
        rst = 1'b0;
        drive(32'd0, NOP, 32'd0, 32'd0);
        step();
    endtask

    task automatic test_add_bypass();
        drive(32'h10, enc_r(7'h00, 3'd0), 32'd99, 32'd7);
        rs1_bypass = 2'b01; alu_m_bypass = 32'd5; wb_w_bypass = 32'd1000;
        step();
        checks++; if (alu_x !== 32'd12) begin errors++; $display("FAIL add_mx alu_x got %h want 0000000c", alu_x); end
        checks++; if (valid_x !== 1'b1 || busy_x !== 1'b0) begin errors++; $display("FAIL add_mx_flags valid=%b busy=%b want 1 0", valid_x, busy_x); end
        $display("txn add_mx alu_x=%h", alu_x);
    endtask

    task automatic test_beq();
        drive(32'h100, enc_b(13'd16, 3'd0), 32'd3, 32'd3);
        step();
        checks++; if (PCSel !== 1'b1 || kill_dx !== 1'b1) begin errors++; $display("FAIL beq_redirect PCSel=%b kill=%b want 1 1", PCSel, kill_dx); end
        checks++; if (alu_x !== 32'h110) begin errors++; $display("FAIL beq_target got %h want 00000110", alu_x); end
        drive(32'h104, enc_r(7'h00, 3'd0), 32'd1, 32'd2);
        step();
        checks++; if (inst_x !== NOP || PC_x !== 32'd0) begin errors++; $display("FAIL beq_squash inst=%h pc=%h want 13 0", inst_x, PC_x); end
        $display("txn beq taken target=110");
    endtask

    task automatic test_alu_random();
        for (int i = 0; i < 40; i++) begin
            logic [31:0] r, x, y, a_sel, b_sel, exp, inst;
            logic [2:0] f3;
            logic [11:0] imm;
            bit alt, is_r;
            r = $urandom;
            f3 = r[2:0]; is_r = r[3];
            alt = r[4] && (f3 == 3'd5 || (f3 == 3'd0 && is_r));
            drive($urandom & 32'hFFFF_FFFC, 32'd0, $urandom, (r[9:8] == 0) ? 32'(r[14:10]) : $urandom);
            rs1_bypass = r[21:20]; rs2_bypass = r[23:22];
            alu_m_bypass = $urandom; wb_w_bypass = $urandom;
            a_sel = pick(rs1_bypass, rs1_d, alu_m_bypass, wb_w_bypass);
            b_sel = pick(rs2_bypass, rs2_d, alu_m_bypass, wb_w_bypass);
            if (f3 == 3'd1 || f3 == 3'd5) imm = {alt ? 7'h20 : 7'h00, r[28:24]};
            else imm = 12'($urandom);
            if (is_r) begin inst = enc_r(alt ? 7'h20 : 7'h00, f3); y = b_sel; end
            else begin inst = enc_i(imm, f3, 7'b0010011); y = {{20{imm[11]}}, imm}; end
            x = a_sel;
            exp = ref_alu(f3, alt, x, y);
            inst_d = inst;
            step();
            checks++; if (alu_x !== exp) begin errors++; $display("FAIL alu_rand%0d inst=%h got %h want %h", i, inst, alu_x, exp); end
            checks++; if (rs2_x !== b_sel) begin errors++; $display("FAIL rs2x_rand%0d got %h want %h", i, rs2_x, b_sel); end
            checks++; if (valid_x !== 1'b1 || PCSel !== 1'b0) begin errors++; $display("FAIL alu_flags%0d valid=%b pcsel=%b want 1 0", i, valid_x, PCSel); end
            $display("txn alu inst=%h a=%h b=%h result=%h", inst, x, y, alu_x);
        end
    endtask

    task automatic test_branch_random();
        logic [2:0] f3s [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        for (int i = 0; i < 24; i++) begin
            logic [31:0] r, pc, x, y, filler, tgt;
            logic [12:0] imm;
            logic [2:0] f3;
            bit tk;
            r = $urandom;
            f3 = f3s[r[2:0] % 6];
            x = $urandom; y = r[3] ? x : (r[4] ? ~x : $urandom);
            imm = {13'($urandom)} & 13'h1FFE;
            pc = $urandom & 32'h0FFF_FFFC;
            tgt = pc + {{19{imm[12]}}, imm};
            tk = ref_taken(f3, x, y);
            drive(pc, enc_b(imm, f3), x, y);
            step();
            checks++; if (PCSel !== tk || kill_dx !== tk) begin errors++; $display("FAIL br%0d f3=%0d PCSel=%b kill=%b want %b", i, f3, PCSel, kill_dx, tk); end
            checks++; if (alu_x !== tgt) begin errors++; $display("FAIL br_tgt%0d got %h want %h", i, alu_x, tgt); end
            filler = enc_i(12'($urandom), 3'd0, 7'b0010011);
            drive(pc + 4, filler, 32'd0, 32'd0);
            step();
            checks++; if (inst_x !== (tk ? NOP : filler)) begin errors++; $display("FAIL br_next%0d got %h want %h", i, inst_x, tk ? NOP : filler); end
            $display("txn branch f3=%0d taken=%0d target=%h", f3, tk, tgt);
        end
    endtask

    task automatic test_jumps();
        logic [31:0] filler;
        filler = enc_i(12'd5, 3'd0, 7'b0010011);
        drive(32'h200, enc_j(21'h20), 32'd0, 32'd0);
        step();
        checks++; if (PCSel !== 1'b1 || kill_dx !== 1'b0 || alu_x !== 32'h220)
            begin errors++; $display("FAIL jal PCSel=%b kill=%b alu=%h want 1 0 00000220", PCSel, kill_dx, alu_x); end
        drive(32'h204, filler, 32'd0, 32'd0);
        step();
        checks++; if (inst_x !== filler) begin errors++; $display("FAIL jal_next got %h want %h", inst_x, filler); end
        drive(32'h300, enc_i(12'hFFC, 3'd0, 7'b1100111), 32'h1000, 32'd0);
        step();
        checks++; if (PCSel !== 1'b1 || kill_dx !== 1'b1 || alu_x !== 32'h0FFC)
            begin errors++; $display("FAIL jalr PCSel=%b kill=%b alu=%h want 1 1 00000ffc", PCSel, kill_dx, alu_x); end
        drive(32'h304, filler, 32'd0, 32'd0);
        step();
        checks++; if (inst_x !== NOP) begin errors++; $display("FAIL jalr_next got %h want 13", inst_x); end
        $display("txn jumps jal=220 jalr=ffc");
    endtask

    task automatic test_back_to_back();
        logic [31:0] insts [4], pcs [4], exps [4];
        insts[0] = {20'hABCDE, 5'd3, 7'b0110111};   pcs[0] = 32'h40; exps[0] = 32'hABCDE000;
        insts[1] = {20'h00001, 5'd3, 7'b0010111};   pcs[1] = 32'h44; exps[1] = 32'h0000_1044;
        insts[2] = enc_i(12'hFF8, 3'd2, 7'b0000011); pcs[2] = 32'h48; exps[2] = 32'h0000_1FF8;
        insts[3] = enc_s(12'h07F);                  pcs[3] = 32'h4C; exps[3] = 32'h0000_037F;
        for (int i = 0; i < 4; i++) begin
            drive(pcs[i], insts[i], 32'd0, 32'd0);
            if (i == 2) begin rs1_bypass = 2'b10; wb_w_bypass = 32'h2000; end
            if (i == 3) begin rs1_d = 32'h300; rs2_bypass = 2'b01; alu_m_bypass = 32'hCAFE_0001; end
            step();
            checks++; if (alu_x !== exps[i] || PC_x !== pcs[i]) begin errors++; $display("FAIL b2b%0d alu=%h pc=%h want %h %h", i, alu_x, PC_x, exps[i], pcs[i]); end
            $display("txn b2b inst=%h result=%h", insts[i], alu_x);
        end
        checks++; if (rs2_x !== 32'hCAFE_0001) begin errors++; $display("FAIL store_data got %h want cafe0001", rs2_x); end
        drive(32'd0, NOP, 32'd0, 32'd0);
        step();
    endtask

`ifdef EXEC_MDU_EN
    function automatic int mdu_cycles(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return XLEN + 1;
    endfunction

    // Called with the MDU op just captured into X; returns in its DONE cycle.
    task automatic wait_mdu(input string name, input logic [31:0] inst, input logic [31:0] pc,
                            input logic [31:0] exp, input int exp_cnt, input bit wiggle);
        int cnt;
        bit hold_bad;
        logic [31:0] r;
        cnt = 0; hold_bad = 1'b0;
        checks++; if (busy_x !== 1'b1 || valid_x !== 1'b0) begin errors++; $display("FAIL %s_entry busy=%b valid=%b want 1 0", name, busy_x, valid_x); end
        while (busy_x === 1'b1 && cnt < 200) begin
            if (PC_x !== pc || inst_x !== inst || valid_x !== 1'b0 || PCSel !== 1'b0 || kill_dx !== 1'b0) hold_bad = 1'b1;
            if (wiggle) begin
                r = $urandom;
                inst_d = {r[31:7], 7'b0010011};
                PC_d = $urandom; rs1_d = $urandom; rs2_d = $urandom;
                rs1_bypass = r[1:0]; rs2_bypass = r[3:2];
                alu_m_bypass = $urandom; wb_w_bypass = $urandom;
            end
            cnt++;
            step();
        end
        checks++; if (hold_bad) begin errors++; $display("FAIL %s_hold X registers or flags moved during stall", name); end
        checks++; if (cnt !== exp_cnt) begin errors++; $display("FAIL %s_busy_cycles got %0d want %0d", name, cnt, exp_cnt); end
        checks++; if (valid_x !== 1'b1 || inst_x !== inst) begin errors++; $display("FAIL %s_done valid=%b inst=%h want 1 %h", name, valid_x, inst_x, inst); end
        checks++; if (alu_x !== exp) begin errors++; $display("FAIL %s_result got %h want %h", name, alu_x, exp); end
        $display("txn %s inst=%h result=%h busy_cycles=%0d", name, inst, alu_x, cnt);
    endtask

    task automatic run_mdu(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit wiggle);
        logic [31:0] inst, pc, nxt, nxt_pc;
        inst = enc_r(7'h01, f3);
        pc = $urandom & 32'hFFFF_FFFC;
        drive(pc, inst, a, b);
        step();
        drive(pc + 4, enc_i(12'($urandom), 3'd0, 7'b0010011), 32'd0, 32'd0);
        wait_mdu(name, inst, pc, ref_mdu(f3, a, b), mdu_cycles(f3, a, b), wiggle);
        nxt = inst_d; nxt_pc = PC_d;
        step();
        checks++; if (inst_x !== nxt || PC_x !== nxt_pc || busy_x !== 1'b0)
            begin errors++; $display("FAIL %s_advance inst=%h pc=%h busy=%b want %h %h 0", name, inst_x, PC_x, busy_x, nxt, nxt_pc); end
        drive(32'd0, NOP, 32'd0, 32'd0);
        step();
    endtask

    task automatic test_mdu_cases();
        run_mdu("mul_neg",  3'd0, 32'hFFFF_FFFA, 32'd7, 1'b0);
        run_mdu("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_mdu("div_neg",  3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_mdu("rem_neg",  3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_mdu("divu_zero", 3'd5, 32'h1234_5678, 32'd0, 1'b0);
        run_mdu("rem_zero", 3'd6, 32'h8765_4321, 32'd0, 1'b0);
        run_mdu("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_mdu("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < 12; i++) begin
            logic [31:0] r;
            r = $urandom;
            run_mdu("mdu_rand", r[2:0], $urandom, (r[5:3] == 0) ? 32'd0 : ((r[6]) ? 32'($urandom_range(1, 300)) : $urandom), 1'b0);
        end
    endtask

    task automatic test_stall_hold();
        run_mdu("hold_mulhsu", 3'd2, 32'h8000_0001, 32'hF000_0003, 1'b1);
        run_mdu("hold_remu",   3'd7, 32'hDEAD_BEEF, 32'h0000_1235, 1'b1);
    endtask

    task automatic test_mdu_back_to_back();
        logic [31:0] i1, i2;
        i1 = enc_r(7'h01, 3'd0); i2 = enc_r(7'h01, 3'd5);
        drive(32'h80, i1, 32'd1234, 32'd5678);
        step();
        drive(32'h84, i2, 32'd1000001, 32'd37);
        wait_mdu("b2b_mul", i1, 32'h80, 32'd1234 * 32'd5678, XLEN + 1, 1'b0);
        step();
        drive(32'h88, NOP, 32'd0, 32'd0);
        wait_mdu("b2b_divu", i2, 32'h84, 32'd1000001 / 32'd37, XLEN + 1, 1'b0);
        step();
    endtask

    task automatic test_reset_run();
        drive(32'h500, enc_r(7'h01, 3'd4), 32'd1000, 32'd3);
        step();
        drive(32'h504, NOP, 32'd0, 32'd0);
        for (int i = 0; i < 11; i++) step();
        checks++; if (busy_x !== 1'b1) begin errors++; $display("FAIL rst_run_pre busy=%b want 1", busy_x); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (busy_x !== 1'b0 || valid_x !== 1'b1) begin errors++; $display("FAIL rst_run_flags busy=%b valid=%b want 0 1", busy_x, valid_x); end
        checks++; if (inst_x !== NOP || PC_x !== 32'd0 || alu_x !== 32'd0) begin errors++; $display("FAIL rst_run_regs inst=%h pc=%h alu=%h want 13 0 0", inst_x, PC_x, alu_x); end
        step();
        checks++; if (busy_x !== 1'b0 || PC_x !== 32'h504) begin errors++; $display("FAIL rst_run_after busy=%b pc=%h want 0 504", busy_x, PC_x); end
        $display("txn reset_during_run");
    endtask
`else
    task automatic test_illegal();
        for (int i = 0; i < 8; i++) begin
            logic [31:0] inst, filler;
            inst = enc_r(7'h01, 3'(i));
            filler = enc_i(12'($urandom), 3'd0, 7'b0010011);
            drive(32'h600 + 32'(i * 8), inst, $urandom, $urandom);
            step();
            checks++; if (illegal_x !== 1'b1 || valid_x !== 1'b1 || busy_x !== 1'b0)
                begin errors++; $display("FAIL illegal%0d ill=%b valid=%b busy=%b want 1 1 0", i, illegal_x, valid_x, busy_x); end
            checks++; if (alu_x !== 32'd0) begin errors++; $display("FAIL illegal_alu%0d got %h want 0", i, alu_x); end
            drive(32'h604 + 32'(i * 8), filler, $urandom, $urandom);
            step();
            checks++; if (inst_x !== filler || illegal_x !== 1'b0) begin errors++; $display("FAIL illegal_next%0d inst=%h ill=%b want %h 0", i, inst_x, illegal_x, filler); end
            $display("txn illegal inst=%h", inst);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        alu_m_bypass = '0; wb_w_bypass = '0;
        drive(32'd0, NOP, 32'd0, 32'd0);
        test_reset();
        test_add_bypass();
        test_beq();
        test_alu_random();
        test_branch_random();
        test_jumps();
        test_back_to_back();
`ifdef EXEC_MDU_EN
        test_mdu_cases();
        test_stall_hold();
        test_mdu_back_to_back();
        test_reset_run();
`else
        test_illegal();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
